// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, flush and a 2-entry skid buffer.
// Define PIPE_STAGE_STALL_CNT_EN to add the saturating downstream-stall counter on stall_cnt_o.
module pipe_stage_hs #(
   parameter int unsigned DW      = 32,
   parameter logic [31:0] NOP_VAL = 32'h00000013,
   parameter int unsigned CNT_W   = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [DW-1:0] in_data_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
`ifdef PIPE_STAGE_STALL_CNT_EN
   output logic [DW-1:0]    out_data_o,
   output logic [CNT_W-1:0] stall_cnt_o
`else
   output logic [DW-1:0] out_data_o
`endif
);

   localparam logic [DW-1:0] NopDw = DW'(NOP_VAL);

   if (DW < 1) begin : g_bad_dw
      $error("pipe_stage_hs: DW must be >= 1");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("pipe_stage_hs: CNT_W must be >= 1");
   end

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] main_q, main_d;
   logic [DW-1:0] skid_q, skid_d;
   logic          in_fire, out_fire;

   assign in_fire  = in_valid_i & in_ready_o;
   assign out_fire = out_valid_o & out_ready_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StEmpty;
         main_q  <= NopDw;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // main always holds the older entry; skid only holds data while FULL
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = StEmpty;
         main_d  = NopDw;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (in_fire) begin
                  state_d = StOne;
                  main_d  = in_data_i;
               end
            end
            StOne: begin
               if (in_fire && out_fire) begin
                  main_d = in_data_i;
               end else if (in_fire) begin
                  state_d = StFull;
                  skid_d  = in_data_i;
               end else if (out_fire) begin
                  state_d = StEmpty;
                  main_d  = NopDw;
               end
            end
            StFull: begin
               if (out_fire) begin
                  state_d = StOne;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = StEmpty;
               main_d  = NopDw;
            end
         endcase
      end
   end

   // Handshake outputs decode the state register only: no combinational ready path.
   always_comb begin
      in_ready_o  = 1'b1;
      out_valid_o = 1'b0;
      unique case (state_q)
         StEmpty: begin
            in_ready_o  = 1'b1;
            out_valid_o = 1'b0;
         end
         StOne: begin
            in_ready_o  = 1'b1;
            out_valid_o = 1'b1;
         end
         StFull: begin
            in_ready_o  = 1'b0;
            out_valid_o = 1'b1;
         end
         default: begin
            in_ready_o  = 1'b1;
            out_valid_o = 1'b0;
         end
      endcase
   end

   assign out_data_o = main_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid_o && !out_ready_i && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // Cleared by reset only; flush leaves the count intact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs: directed steps plus randomized traffic against a queue model.
// Stall-counter checks are compiled in when PIPE_STAGE_STALL_CNT_EN is defined.
module tb_pipe_stage_hs;

   localparam int unsigned DW      = 32;
   localparam int unsigned CNT_W   = 4;
   localparam logic [31:0] NOP     = 32'h00000013;
   localparam int unsigned CNT_MAX = 15;

   logic          clk;
   logic          rst;
   logic          flush_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [DW-1:0] in_data_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [DW-1:0] out_data_o;
`ifdef PIPE_STAGE_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_o;
`endif

   pipe_stage_hs #(
      .DW      (DW),
      .NOP_VAL (NOP),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
`ifdef PIPE_STAGE_STALL_CNT_EN
      .out_data_o  (out_data_o),
      .stall_cnt_o (stall_cnt_o)
`else
      .out_data_o  (out_data_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: FIFO of held payloads (capacity 2) and stall count.
   logic [31:0] q[$];
   int unsigned cnt_m;
   int unsigned n_checks;
   int unsigned n_errors;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] exp_data;
      exp_data = (q.size() > 0) ? q[0] : NOP;
      chk("out_valid", {31'b0, out_valid_o}, {31'b0, q.size() > 0});
      chk("in_ready", {31'b0, in_ready_o}, {31'b0, q.size() < 2});
      chk("out_data", out_data_o, exp_data);
`ifdef PIPE_STAGE_STALL_CNT_EN
      chk("stall_cnt", {28'b0, stall_cnt_o}, cnt_m);
`endif
   endtask

   // Drive one cycle's inputs, advance the model across the edge, then compare.
   task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
      bit acc, pop, stall;
      in_valid_i  = v;
      in_data_i   = d;
      out_ready_i = r;
      flush_i     = f;
      acc   = v && (q.size() < 2);
      pop   = r && (q.size() > 0);
      stall = (q.size() > 0) && !r;
      @(posedge clk);
      if (stall && cnt_m < CNT_MAX) cnt_m++;
      if (f) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(d);
      end
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      q.delete();
      cnt_m = 0;
      check_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      cnt_m       = 0;
      rst         = 1'b1;
      flush_i     = 1'b0;
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      out_ready_i = 1'b0;
      #2;
      check_all();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all();

      // Reset asserted while FULL takes effect without a clock edge
      cycle(1'b1, 32'hA, 1'b0, 1'b0);
      cycle(1'b1, 32'hB, 1'b0, 1'b0);
      chk("full_in_ready", {31'b0, in_ready_o}, 32'd0);
      do_reset();
      chk("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready_o}, 32'd1);
      chk("rst_out_data", out_data_o, NOP);

      // Streaming 1..4 back to back
      for (int i = 1; i <= 4; i++) begin
         cycle(1'b1, 32'(i), 1'b1, 1'b0);
         chk("stream_data", out_data_o, 32'(i));
         chk("stream_ready", {31'b0, in_ready_o}, 32'd1);
      end
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("stream_drain", {31'b0, out_valid_o}, 32'd0);

      // Backpressure
      cycle(1'b1, 32'hA, 1'b0, 1'b0);
      cycle(1'b1, 32'hB, 1'b0, 1'b0);
      chk("bp_in_ready", {31'b0, in_ready_o}, 32'd0);
      chk("bp_hold", out_data_o, 32'hA);
      cycle(1'b1, 32'hDEAD, 1'b0, 1'b0);
      chk("bp_still_a", out_data_o, 32'hA);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bp_pop_b", out_data_o, 32'hB);
      chk("bp_ready_back", {31'b0, in_ready_o}, 32'd1);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bp_empty", out_data_o, NOP);

      // Flush while FULL with a simultaneous input
      cycle(1'b1, 32'hA, 1'b0, 1'b0);
      cycle(1'b1, 32'hB, 1'b0, 1'b0);
      cycle(1'b1, 32'hC, 1'b0, 1'b1);
      chk("flush_valid", {31'b0, out_valid_o}, 32'd0);
      chk("flush_data", out_data_o, NOP);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("flush_no_c", {31'b0, out_valid_o}, 32'd0);

      // Randomized valid/ready/flush traffic
      for (int i = 0; i < 10000; i++) begin
         cycle(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 6),
               ($urandom_range(0, 63) == 0));
      end

`ifdef PIPE_STAGE_STALL_CNT_EN
      do_reset();
      cycle(1'b1, 32'h55, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
      chk("cnt_sat", {28'b0, stall_cnt_o}, 32'd15);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      chk("cnt_flush", {28'b0, stall_cnt_o}, 32'd15);
      do_reset();
      chk("cnt_rst", {28'b0, stall_cnt_o}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
